// File: rtl/prism_sp_cmd_arbiter.sv
// Round-robin arbiter sharing one command engine between NUM_REQ issuers,
// with per-requester busy/done/error tracking and a completion watchdog.
module prism_sp_cmd_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned CMD_W          = 64,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*CMD_W-1:0]     req_cmd,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_ack,
    output logic [NUM_REQ-1:0]           req_busy,
    output logic [NUM_REQ-1:0]           req_done,
    output logic [NUM_REQ-1:0]           req_error,
    output logic                         eng_valid,
    output logic [CMD_W-1:0]             eng_cmd,
    output logic [$clog2(NUM_REQ)-1:0]   eng_id,
    input  logic                         eng_ready,
    input  logic                         eng_done,
    output logic                         eng_abort
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [TO_W-1:0]   wd_cnt;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant_oh;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   grant_next;
    logic [CMD_W-1:0]  grant_cmd;
    logic              timeout_hit;
    int unsigned       scan_idx;

    // A requester holding an unacknowledged done cannot be granted again.
    assign eligible = req_valid & ~req_busy & ~req_done;

    // First eligible requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_oh    = '0;
        grant_idx   = '0;
        grant_next  = '0;
        scan_idx    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && eligible[scan_idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(scan_idx);
                grant_next  = ID_W'((scan_idx + 1) % NUM_REQ);
            end
        end
        if (state != S_IDLE || rst) begin
            grant_found = 1'b0;
        end
        if (grant_found) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        grant_cmd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                grant_cmd = req_cmd[i*CMD_W +: CMD_W];
            end
        end
    end

    assign req_ready   = grant_oh;
    assign timeout_hit = WD_EN && (wd_cnt == TO_LAST);
    // A same-cycle eng_done takes precedence over the watchdog.
    assign eng_abort   = !rst && (state == S_WAIT) && !eng_done && timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            wd_cnt    <= '0;
            req_busy  <= '0;
            req_done  <= '0;
            req_error <= '0;
            eng_valid <= 1'b0;
            eng_cmd   <= '0;
            eng_id    <= '0;
        end else begin
            req_done  <= req_done & ~req_ack;
            req_error <= req_error & ~req_ack;
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        eng_cmd   <= grant_cmd;
                        eng_id    <= grant_idx;
                        req_busy  <= grant_oh;
                        rr_ptr    <= grant_next;
                        eng_valid <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (eng_ready) begin
                        eng_valid <= 1'b0;
                        wd_cnt    <= '0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wd_cnt != '1) begin
                        wd_cnt <= wd_cnt + TO_W'(1);
                    end
                    if (eng_done || timeout_hit) begin
                        req_busy          <= '0;
                        req_done[eng_id]  <= 1'b1;
                        req_error[eng_id] <= !eng_done;
                        state             <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
